timestamp_capture: RTL and testbench

Captures timestamps of external events against the free-running counter. Sits directly downstream of the `counter` block and consumes its `count` value and `overflow` strobe. It extends the counter into a wider timestamp using an epoch register that increments on each counter wrap. On each rising edge of `event_in`, it queues `{epoch, count}` in a small FIFO, which software or a DMA stage drains through a valid/ready interface.

---
 rtl/timestamp_capture_pkg.sv | 16 +
 rtl/timestamp_capture_ts_fifo.sv | 83 ++++++++
 rtl/timestamp_capture.sv | 107 ++++++++++
 tb/tb_timestamp_capture.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/timestamp_capture_pkg.sv
// ----------------------------------------------------------------------------
// timestamp_pkg
// Shared constants and helpers for the timestamp capture slice.
//   DROP_W   : width of the saturating dropped-event counter
//   ts_width : width of a captured timestamp word ({epoch, count})
// ----------------------------------------------------------------------------
package timestamp_pkg;

   localparam int DROP_W = 8;

   // Timestamp word is the epoch (wrap count) concatenated above the raw count.
   function automatic int ts_width(input int epoch_w, input int width);
      return epoch_w + width;
   endfunction

endpackage

// File: rtl/timestamp_capture_ts_fifo.sv
// ----------------------------------------------------------------------------
// ts_fifo
// Synchronous single-clock FIFO holding captured timestamps.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_wdata (ignored when full unless popping this cycle)
//   i_wdata     : data to write
//   i_pop       : consume head (ignored when empty)
//   o_rdata     : current head, combinational read of the storage
//   o_full      : level == DEPTH
//   o_empty     : level == 0
//   o_level     : registered occupancy, 0..DEPTH
// Read-first: on a simultaneous push and pop at full the write lands in the
// slot the head is leaving; the old head is still presented during that cycle.
// ----------------------------------------------------------------------------
module ts_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [DATA_W-1:0]          i_wdata,
   input  logic                       i_pop,
   output logic [DATA_W-1:0]          o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [LW-1:0]     r_level;

   logic              w_push;
   logic              w_pop;

   assign o_full  = (r_level == LW'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_rdata = r_mem[r_rptr];

   // Qualified strobes: a pop frees a slot in the same cycle, so a push at
   // full is accepted when paired with a pop.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   // Storage is reset so the head reads as zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/timestamp_capture.sv
// ----------------------------------------------------------------------------
// timestamp_capture
// Extends an upstream free-running counter into a wider timestamp using an
// epoch (wrap) register, and queues {epoch, count} on each rising edge of
// i_event_in for a valid/ready consumer.
//   clk, rst_n      : clock (counter domain), asynchronous active-low reset
//   i_count         : current counter value
//   i_overflow      : counter wrap strobe (count at MAX with enable)
//   i_event_in      : synchronous event line, captured on rising edge
//   i_epoch_clear   : clear epoch (wins over i_overflow)
//   i_stats_clear   : clear o_dropped (wins over a coincident drop)
//   o_ts_valid      : FIFO head valid
//   i_ts_ready      : consumer accepts head
//   o_ts_data       : FIFO head {epoch, count}
//   o_level         : FIFO occupancy
//   o_dropped       : events lost to a full FIFO, saturating
// ----------------------------------------------------------------------------
module timestamp_capture
   import timestamp_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int EPOCH_W = 8,
   parameter int DEPTH   = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [WIDTH-1:0]                    i_count,
   input  logic                                i_overflow,
   input  logic                                i_event_in,
   input  logic                                i_epoch_clear,
   input  logic                                i_stats_clear,
   output logic                                o_ts_valid,
   input  logic                                i_ts_ready,
   output logic [ts_width(EPOCH_W, WIDTH)-1:0] o_ts_data,
   output logic [$clog2(DEPTH):0]              o_level,
   output logic [DROP_W-1:0]                   o_dropped
);

   localparam int TS_W = ts_width(EPOCH_W, WIDTH);

   logic [EPOCH_W-1:0] r_epoch;
   logic               r_event_q;
   logic [DROP_W-1:0]  r_dropped;

   logic               w_edge;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic               w_full;
   logic               w_empty;
   logic [TS_W-1:0]    w_sample;

   // ---------------------------------------------------------------- epoch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             r_epoch <= '0;
      else if (i_epoch_clear) r_epoch <= '0;
      else if (i_overflow)    r_epoch <= r_epoch + EPOCH_W'(1);
   end

   // ---------------------------------------------------------- edge detect
   // Resets high so a line already asserted when reset releases is not
   // mistaken for a fresh event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_event_q <= 1'b1;
      else        r_event_q <= i_event_in;
   end

   assign w_edge = i_event_in & ~r_event_q;

   // Sample uses the pre-update epoch, so the overflow cycle pairs
   // count=MAX with the old epoch and the pair stays monotonic.
   assign w_sample = {r_epoch, i_count};

   // ------------------------------------------------------- push/pop gating
   assign w_pop  = o_ts_valid & i_ts_ready;
   assign w_push = w_edge & (~w_full | w_pop);
   assign w_drop = w_edge & w_full & ~w_pop;

   // ------------------------------------------------------- drop counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             r_dropped <= '0;
      else if (i_stats_clear) r_dropped <= '0;
      else if (w_drop && (r_dropped != {DROP_W{1'b1}}))
                              r_dropped <= r_dropped + DROP_W'(1);
   end

   assign o_dropped = r_dropped;

   // ---------------------------------------------------------------- FIFO
   ts_fifo #(
      .DATA_W (TS_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (w_sample),
      .i_pop   (w_pop),
      .o_rdata (o_ts_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_level)
   );

   assign o_ts_valid = ~w_empty;

endmodule

// File: tb/tb_timestamp_capture.sv
// ----------------------------------------------------------------------------
// tb_timestamp_capture
// Scoreboard bench: expected timestamps are queued as events are driven and
// compared when the consumer pops them; level/dropped follow a small model.
// ----------------------------------------------------------------------------
module tb_timestamp_capture;

   localparam int W  = 8;
   localparam int EW = 8;
   localparam int D  = 4;
   localparam int TW = EW + W;
   localparam int LW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  count;
   logic          overflow, event_in, epoch_clear, stats_clear, ts_ready;
   logic          ts_valid;
   logic [TW-1:0] ts_data;
   logic [LW-1:0] level;
   logic [7:0]    dropped;

   int checks   = 0;
   int failures = 0;

   logic [TW-1:0] sb[$];
   int            m_level, m_dropped;
   logic [EW-1:0] m_epoch;
   logic          m_evq;

   always #5 clk = ~clk;

   timestamp_capture #(.WIDTH(W), .EPOCH_W(EW), .DEPTH(D)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_count       (count),
      .i_overflow    (overflow),
      .i_event_in    (event_in),
      .i_epoch_clear (epoch_clear),
      .i_stats_clear (stats_clear),
      .o_ts_valid    (ts_valid),
      .i_ts_ready    (ts_ready),
      .o_ts_data     (ts_data),
      .o_level       (level),
      .o_dropped     (dropped)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_level = 0; m_dropped = 0; m_epoch = '0; m_evq = 1'b1;
      sb.delete();
   endtask

   // One clock cycle. Inputs are already set (at a negedge); check the head
   // if a pop is due, advance the model across the posedge, then check state
   // at the following negedge.
   task automatic step();
      logic edge_d, pop, full, push, drop;
      logic [TW-1:0] exp;
      edge_d = event_in & ~m_evq;
      pop    = (m_level != 0) && ts_ready;
      full   = (m_level == D);
      push   = edge_d && (!full || pop);
      drop   = edge_d && full && !pop;
      if (pop) begin
         if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else begin
            exp = sb.pop_front();
            chk("ts_data_pop", 32'(ts_data), 32'(exp));
         end
      end
      if (push) sb.push_back({m_epoch, count});
      m_level = m_level + (push ? 1 : 0) - (pop ? 1 : 0);
      if (stats_clear) m_dropped = 0;
      else if (drop && m_dropped < 255) m_dropped++;
      if (epoch_clear) m_epoch = '0;
      else if (overflow) m_epoch = m_epoch + 1'b1;
      m_evq = event_in;
      @(posedge clk);
      @(negedge clk);
      chk("level", 32'(level), 32'(m_level));
      chk("dropped", 32'(dropped), 32'(m_dropped));
      chk("ts_valid", 32'(ts_valid), 32'(m_level != 0));
   endtask

   task automatic pulse(input logic [W-1:0] c);
      count = c; event_in = 1'b1; step();
      event_in = 1'b0; step();
   endtask

   task automatic drain();
      ts_ready = 1'b1;
      for (int i = 0; i < D + 1; i++) step();
      ts_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; count = '0; overflow = 0; event_in = 0;
      epoch_clear = 0; stats_clear = 0; ts_ready = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(ts_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_dropped", 32'(dropped), 32'd0);
      chk("rst_data", 32'(ts_data), 32'd0);
      rst_n = 1'b1;
      step();

      // Basic capture
      count = 8'h37; event_in = 1'b1; step();
      chk("basic_data", 32'(ts_data), 32'h0037);
      chk("basic_level", 32'(level), 32'd1);
      event_in = 1'b0; step();
      drain();

      // Wrap coherence
      count = 8'hFF; overflow = 1'b1; event_in = 1'b1; step();
      overflow = 1'b0; event_in = 1'b0; count = 8'h00; step();
      count = 8'h02; event_in = 1'b1; step();
      event_in = 1'b0; step();
      chk("wrap_head", 32'(ts_data), 32'h00FF);
      ts_ready = 1'b1; step();
      chk("wrap_next", 32'(ts_data), 32'h0102);
      step(); ts_ready = 1'b0;

      // Full and drop
      for (int i = 0; i < 6; i++) pulse(8'(8'h10 + i));
      chk("full_level", 32'(level), 32'd4);
      chk("full_dropped", 32'(dropped), 32'd2);

      // Full with simultaneous pop
      count = 8'h55; event_in = 1'b1; ts_ready = 1'b1; step();
      chk("fullpop_level", 32'(level), 32'd4);
      chk("fullpop_dropped", 32'(dropped), 32'd2);
      event_in = 1'b0; ts_ready = 1'b0; step();
      drain();
      chk("drained_level", 32'(level), 32'd0);

      // Epoch clear beats overflow (epoch is 1 here)
      overflow = 1'b1; epoch_clear = 1'b1; step();
      overflow = 1'b0; epoch_clear = 1'b0;
      pulse(8'h10);
      chk("eclr_data", 32'(ts_data), 32'h0010);
      drain();

      // Drop saturation, then stats_clear beating a new drop
      for (int i = 0; i < D; i++) pulse(8'(i));
      for (int i = 0; i < 260; i++) pulse(8'hAA);
      chk("drop_sat", 32'(dropped), 32'd255);
      event_in = 1'b1; stats_clear = 1'b1; step();
      chk("sclr_drop", 32'(dropped), 32'd0);
      event_in = 1'b0; stats_clear = 1'b0; step();
      drain();

      // Held-high event captures once
      count = 8'h77; event_in = 1'b1;
      repeat (5) step();
      chk("held_level", 32'(level), 32'd1);
      event_in = 1'b0; step();
      drain();

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         count    = 8'($urandom);
         overflow = ($urandom_range(0, 7) == 0);
         event_in = $urandom_range(0, 1);
         ts_ready = ($urandom_range(0, 2) == 0);
         step();
      end
      overflow = 1'b0; event_in = 1'b0;
      drain();

      // Mid-operation reset with 3 entries queued, line left high
      for (int i = 0; i < 3; i++) pulse(8'(8'h20 + i));
      chk("pre_rst_level", 32'(level), 32'd3);
      event_in = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(ts_valid), 32'd0);
      chk("midrst_level", 32'(level), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      chk("post_rst_level", 32'(level), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
